// File: rtl/boot_pkg.sv
// Shared types for the instruction-memory boot loader.
// BOOT_CHECKSUM_EN (optional) adds the CHECK state's trailing XOR byte.
package boot_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
        CHECK  = 3'd4,
        DONE   = 3'd5,
        ERROR  = 3'd6
    } boot_state_t;

    typedef logic [1:0] boot_err_t;

    localparam boot_err_t ERR_NONE    = 2'd0;
    localparam boot_err_t ERR_LEN     = 2'd1;
    localparam boot_err_t ERR_TIMEOUT = 2'd2;
    localparam boot_err_t ERR_CSUM    = 2'd3;

    function automatic logic is_loading(input boot_state_t s);
        return s inside {LEN_LO, LEN_HI, DATA, CHECK};
    endfunction

endpackage

// File: rtl/boot_word_packer.sv
// Little-endian byte-to-word assembler: byte k lands in bits [8k+7:8k],
// and word/word_valid are registered one cycle after the final byte.
module boot_word_packer #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  word_end,
    output logic                  word_valid,
    output logic [DATA_WIDTH-1:0] word
);

    localparam int unsigned BPW = DATA_WIDTH / 8;
    localparam int unsigned CW  = (BPW > 1) ? $clog2(BPW) : 1;

    logic [CW-1:0]         cnt_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] shifted;

    // Newest byte enters at the top, so after BPW bytes byte 0 sits at the bottom.
    assign shifted  = (shift_q >> 8) | (DATA_WIDTH'(byte_data) << (DATA_WIDTH - 8));
    assign word_end = byte_valid && (cnt_q == CW'(BPW - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q      <= '0;
            shift_q    <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                cnt_q   <= '0;
                shift_q <= '0;
            end else if (byte_valid) begin
                shift_q <= shifted;
                if (word_end) begin
                    cnt_q      <= '0;
                    word       <= shifted;
                    word_valid <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Streams a length-prefixed program image into imem and holds the core in reset until done.
// BOOT_CHECKSUM_EN enables a trailing XOR byte checked in the CHECK state.
module imem_boot_loader
    import boot_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [DATA_WIDTH-1:0] imem_wdata,
    output logic                  cpu_reset,
    output logic                  done,
    output logic [1:0]            err_code
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
`ifdef BOOT_CHECKSUM_EN
    localparam boot_state_t AFTER_LOAD = CHECK;
`else
    localparam boot_state_t AFTER_LOAD = DONE;
`endif

    boot_state_t           state_q, state_d;
    boot_err_t             err_d;
    logic [7:0]            len_lo_q;
    logic [15:0]           len_q;
    logic [ADDR_WIDTH-1:0] word_cnt_q;
    logic [TW-1:0]         tmo_q;
    logic                  accept, pack_valid, word_end, last_word, tmo_expire;
    logic [16:0]           len_rx;

    assign accept     = in_valid && in_ready;
    assign pack_valid = accept && (state_q == DATA) && !start;
    assign len_rx     = {1'b0, in_data, len_lo_q};
    assign last_word  = (17'(word_cnt_q) + 17'd1) == 17'(len_q);
    // A byte accepted on the expiry cycle wins over the timeout.
    assign tmo_expire = is_loading(state_q) && (tmo_q == TW'(TIMEOUT_CYCLES - 1)) && !accept;

`ifdef BOOT_CHECKSUM_EN
    logic [7:0] csum_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                       csum_q <= '0;
        else if (start)                     csum_q <= '0;
        else if (state_q == DATA && accept) csum_q <= csum_q ^ in_data;
    end
`endif

    always_comb begin
        state_d = state_q;
        err_d   = err_code;
        if (start) begin
            state_d = LEN_LO;
            err_d   = ERR_NONE;
        end else if (tmo_expire) begin
            state_d = ERROR;
            err_d   = ERR_TIMEOUT;
        end else begin
            case (state_q)
                LEN_LO: if (accept) state_d = LEN_HI;
                LEN_HI: begin
                    if (accept) begin
                        if (len_rx > (17'd1 << ADDR_WIDTH)) begin
                            state_d = ERROR;
                            err_d   = ERR_LEN;
                        end else if (len_rx == 17'd0) begin
                            state_d = AFTER_LOAD;
                        end else begin
                            state_d = DATA;
                        end
                    end
                end
                DATA: if (word_end && last_word) state_d = AFTER_LOAD;
`ifdef BOOT_CHECKSUM_EN
                CHECK: begin
                    if (accept) begin
                        if (in_data == csum_q) begin
                            state_d = DONE;
                        end else begin
                            state_d = ERROR;
                            err_d   = ERR_CSUM;
                        end
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    // Status outputs are registered from the next state so they track it with no lag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            err_code   <= ERR_NONE;
            in_ready   <= 1'b0;
            cpu_reset  <= 1'b1;
            done       <= 1'b0;
            len_lo_q   <= '0;
            len_q      <= '0;
            word_cnt_q <= '0;
            imem_addr  <= '0;
            tmo_q      <= '0;
        end else begin
            state_q   <= state_d;
            err_code  <= err_d;
            in_ready  <= is_loading(state_d);
            cpu_reset <= (state_d != DONE);
            done      <= (state_d == DONE);
            if (state_q == LEN_LO && accept) len_lo_q <= in_data;
            if (state_q == LEN_HI && accept) len_q <= len_rx[15:0];
            if (start || accept)             tmo_q <= '0;
            else if (is_loading(state_q))    tmo_q <= tmo_q + 1'b1;
            if (start) begin
                word_cnt_q <= '0;
            end else if (word_end) begin
                word_cnt_q <= word_cnt_q + 1'b1;
                imem_addr  <= word_cnt_q;
            end
        end
    end

    boot_word_packer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_packer (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (start),
        .byte_valid (pack_valid),
        .byte_data  (in_data),
        .word_end   (word_end),
        .word_valid (imem_we),
        .word       (imem_wdata)
    );

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: stimulus queues expected writes and status
// events, a negedge monitor pops and compares them as the DUT presents them.
module tb_imem_boot_loader;

    localparam int unsigned DW  = 32;
    localparam int unsigned AW  = 4;
    localparam int unsigned TMO = 50;

    localparam int EV_WRITE = 0;
    localparam int EV_DONE  = 1;
    localparam int EV_ERR   = 2;

    logic          clk = 1'b0;
    logic          reset_n, start, in_valid;
    logic [7:0]    in_data;
    logic          in_ready, imem_we, cpu_reset, done;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_wdata;
    logic [1:0]    err_code;

    typedef struct {
        int            kind;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } ev_t;

    ev_t  exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    logic done_prev = 1'b0;
    logic [1:0] err_prev = 2'd0;

    imem_boot_loader #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .done       (done),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_ev(input int kind, input logic [AW-1:0] a, input logic [DW-1:0] d);
        ev_t e;
        e.kind = kind;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic expect_ev(input int kind, input logic [AW-1:0] a, input logic [DW-1:0] d);
        ev_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL event: got kind %0d addr %0d data 0x%0h want no event", kind, a, d);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.addr !== a || e.data !== d) begin
                n_fail++;
                $display("FAIL event: got kind %0d addr %0d data 0x%0h want kind %0d addr %0d data 0x%0h",
                         kind, a, d, e.kind, e.addr, e.data);
            end
        end
    endtask

    always @(negedge clk) begin
        if (imem_we) expect_ev(EV_WRITE, imem_addr, imem_wdata);
        if (done && !done_prev) expect_ev(EV_DONE, '0, '0);
        if (err_code != err_prev && err_code != 2'd0) expect_ev(EV_ERR, '0, DW'(err_code));
        done_prev = done;
        err_prev  = err_code;
    end

    // All stimulus tasks start and end 1 time unit after a rising edge.
    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int guard = 0;
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_stall: in_ready got 0 want 1 for byte 0x%02h", b);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
    endtask

    task automatic send_csum(input logic [7:0] b);
`ifdef BOOT_CHECKSUM_EN
        send_byte(b);
`else
        if (b === 8'hxx) $display("unused");
`endif
    endtask

    task automatic wait_end();
        int g = 0;
        while (!done && err_code == 2'd0 && g < 200) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (g >= 200) begin
            n_cmp++;
            n_fail++;
            $display("FAIL wait_end: no done or error after %0d cycles", g);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_cpu_reset"}, cpu_reset, 1);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_imem_we"}, imem_we, 0);
        check({tag, "_imem_addr"}, imem_addr, 0);
        check({tag, "_imem_wdata"}, imem_wdata, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err_code"}, err_code, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  x;
        logic [31:0] w;
        int          c;

        reset_n  = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1 check_reset_vals("reset");
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        #1 check("idle_in_ready", in_ready, 0);

        // Nominal two-word image.
        push_ev(EV_WRITE, 4'd0, 32'h12345678);
        push_ev(EV_WRITE, 4'd1, 32'hDEADBEEF);
        push_ev(EV_DONE, '0, '0);
        pulse_start();
        check("start_in_ready", in_ready, 1);
        send_byte(8'h02); send_byte(8'h00);
        send_word(32'h12345678);
        send_word(32'hDEADBEEF);
        send_csum(8'h2A);
        wait_end();
        check("nominal_done", done, 1);
        check("nominal_cpu_reset", cpu_reset, 0);
        check("nominal_err", err_code, 0);
        check("nominal_in_ready", in_ready, 0);

        // Restart from DONE rewrites addr 0.
        pulse_start();
        check("restart_cpu_reset", cpu_reset, 1);
        check("restart_done", done, 0);
        push_ev(EV_WRITE, 4'd0, 32'h11223344);
        push_ev(EV_DONE, '0, '0);
        send_byte(8'h01); send_byte(8'h00);
        send_word(32'h11223344);
        send_csum(8'h44);
        wait_end();
        check("restart_done2", done, 1);

        // N = 17 exceeds the 16-word memory.
        push_ev(EV_ERR, '0, 32'd1);
        pulse_start();
        send_byte(8'h11); send_byte(8'h00);
        wait_end();
        check("ovf_err", err_code, 1);
        check("ovf_cpu_reset", cpu_reset, 1);
        check("ovf_done", done, 0);

        // N = 16 fills the memory exactly.
        pulse_start();
        check("full_err_cleared", err_code, 0);
        send_byte(8'h10); send_byte(8'h00);
        x = 8'h00;
        for (int i = 0; i < 16; i++) begin
            w = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
            x = x ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
            push_ev(EV_WRITE, 4'(i), w);
            send_word(w);
        end
        push_ev(EV_DONE, '0, '0);
        send_csum(x);
        wait_end();
        check("full_done", done, 1);

        // Empty image.
        push_ev(EV_DONE, '0, '0);
        pulse_start();
        send_byte(8'h00); send_byte(8'h00);
        send_csum(8'h00);
        wait_end();
        check("empty_done", done, 1);

        // Timeout 50 cycles after the last accepted byte.
        push_ev(EV_ERR, '0, 32'd2);
        pulse_start();
        send_byte(8'h01); send_byte(8'h00); send_byte(8'hAA);
        c = 0;
        while (err_code == 2'd0 && c < 100) begin
            @(posedge clk);
            #1;
            c++;
        end
        check("timeout_cycles", c, TMO);
        check("timeout_err", err_code, 2);
        check("timeout_in_ready", in_ready, 0);

        // Asynchronous reset while in DATA.
        pulse_start();
        send_byte(8'h01); send_byte(8'h00); send_byte(8'hDD); send_byte(8'hCC);
        #2 reset_n = 1'b0;
        #1 check_reset_vals("midreset");
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        #1;
        push_ev(EV_WRITE, 4'd0, 32'hAABBCCDD);
        push_ev(EV_DONE, '0, '0);
        pulse_start();
        send_byte(8'h01); send_byte(8'h00);
        send_word(32'hAABBCCDD);
        send_csum(8'h00);
        wait_end();
        check("after_reset_done", done, 1);

`ifdef BOOT_CHECKSUM_EN
        push_ev(EV_WRITE, 4'd0, 32'h44332211);
        push_ev(EV_DONE, '0, '0);
        pulse_start();
        send_byte(8'h01); send_byte(8'h00);
        send_word(32'h44332211);
        send_byte(8'h44);
        wait_end();
        check("csum_good_done", done, 1);

        push_ev(EV_WRITE, 4'd0, 32'h44332211);
        push_ev(EV_ERR, '0, 32'd3);
        pulse_start();
        send_byte(8'h01); send_byte(8'h00);
        send_word(32'h44332211);
        send_byte(8'h05);
        wait_end();
        check("csum_bad_err", err_code, 3);
        check("csum_bad_done", done, 0);
        check("csum_bad_cpu_reset", cpu_reset, 1);
`endif

        repeat (3) @(posedge clk);
        #1 check("events_pending", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
